// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : shares one MemRdy-handshaked memory port between two
//                   requesters. Define MEM_TIMEOUT_EN to abort stalled accesses.
// Revision 1.0
// ============================================================================
module mem_bus_arbiter #(
  parameter int unsigned FIXED_PRIO     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0Enable,
  input  logic        Req0Rd,
  input  logic        Req0Wr,
  input  logic        Req0Length,
  input  logic [23:0] Req0Addr,
  input  logic [31:0] Req0WrData,
  output logic [31:0] Req0RdData,
  output logic        Req0Rdy,
  input  logic        Req1Enable,
  input  logic        Req1Rd,
  input  logic        Req1Wr,
  input  logic        Req1Length,
  input  logic [23:0] Req1Addr,
  input  logic [31:0] Req1WrData,
  output logic [31:0] Req1RdData,
  output logic        Req1Rdy,
  output logic [23:0] MemAddr,
  output logic [31:0] toMemData,
  input  logic [31:0] fromMemData,
  output logic        MemLength,
  output logic        MemRd,
  output logic        MemWr,
  output logic        MemEnable,
  input  logic        MemRdy,
  output logic [1:0]  Grant,
  output logic        MemErr
);

  localparam logic [31:0] C_ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..1023");
  end

  state_t      state_q, state_d;
  logic        last_q, last_d;     // index of the requester granted most recently
  logic [1:0]  grant_q, grant_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        len_q, len_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        en_q, en_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        rdy0_q, rdy0_d;
  logic        rdy1_q, rdy1_d;

  logic w_valid0, w_valid1, w_pick1, w_timeout;

  assign w_valid0 = Req0Enable && (Req0Rd != Req0Wr);
  assign w_valid1 = Req1Enable && (Req1Rd != Req1Wr);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    len_d    = len_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    en_d     = en_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rdy0_d   = 1'b0;
    rdy1_d   = 1'b0;
    w_pick1  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_valid0 || w_valid1) begin
          if (w_valid0 && w_valid1) begin
            w_pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
          end else begin
            w_pick1 = w_valid1;
          end
          addr_d  = w_pick1 ? Req1Addr   : Req0Addr;
          wdata_d = w_pick1 ? Req1WrData : Req0WrData;
          len_d   = w_pick1 ? Req1Length : Req0Length;
          rd_d    = w_pick1 ? Req1Rd     : Req0Rd;
          wr_d    = w_pick1 ? Req1Wr     : Req0Wr;
          en_d    = 1'b1;
          grant_d = w_pick1 ? 2'b10 : 2'b01;
          last_d  = w_pick1;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // A real completion takes precedence over a coincident timeout.
        if (MemRdy || w_timeout) begin
          en_d    = 1'b0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_DONE;
          if (grant_q[1]) begin
            rdy1_d = 1'b1;
            if (!MemRdy)   rdata1_d = C_ABORT_DATA;
            else if (rd_q) rdata1_d = fromMemData;
          end else begin
            rdy0_d = 1'b1;
            if (!MemRdy)   rdata0_d = C_ABORT_DATA;
            else if (rd_q) rdata0_d = fromMemData;
          end
        end
      end
      S_DONE: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      grant_q  <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      len_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      en_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rdy0_q   <= 1'b0;
      rdy1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      len_q    <= len_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      en_q     <= en_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rdy0_q   <= rdy0_d;
      rdy1_q   <= rdy1_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [9:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // The counter idles at zero, so it is already clear on entry to ACCESS.
  always_comb begin
    cnt_d = '0;
    err_d = 1'b0;
    if (state_q == S_ACCESS) begin
      cnt_d = cnt_q + 10'd1;
      err_d = !MemRdy && w_timeout;
    end
  end

  assign w_timeout = (cnt_q == 10'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign MemErr = err_q;
`else
  assign w_timeout = 1'b0;
  assign MemErr    = 1'b0;
`endif

  assign MemAddr    = addr_q;
  assign toMemData  = wdata_q;
  assign MemLength  = len_q;
  assign MemRd      = rd_q;
  assign MemWr      = wr_q;
  assign MemEnable  = en_q;
  assign Grant      = grant_q;
  assign Req0RdData = rdata0_q;
  assign Req1RdData = rdata1_q;
  assign Req0Rdy    = rdy0_q;
  assign Req1Rdy    = rdy1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// tb_mem_bus_arbiter : drives a round-robin and a fixed-priority copy of
// mem_bus_arbiter from shared requester and memory stimulus.
module tb_mem_bus_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        r0_en, r0_rd, r0_wr, r0_len;
  logic [23:0] r0_addr;
  logic [31:0] r0_wd;
  logic        r1_en, r1_rd, r1_wr, r1_len;
  logic [23:0] r1_addr;
  logic [31:0] r1_wd;
  logic        mem_rdy;
  logic [31:0] from_mem;

  logic [31:0] rr_rdata0, rr_rdata1, fp_rdata0, fp_rdata1;
  logic        rr_rdy0, rr_rdy1, fp_rdy0, fp_rdy1;
  logic [23:0] rr_addr, fp_addr;
  logic [31:0] rr_wd, fp_wd;
  logic        rr_len, rr_rd, rr_wr, rr_en, rr_err;
  logic        fp_len, fp_rd, fp_wr, fp_en, fp_err;
  logic [1:0]  rr_grant, fp_grant;

  mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT_CYCLES(8)) u_rr (
    .Clk(Clk), .Reset(Reset),
    .Req0Enable(r0_en), .Req0Rd(r0_rd), .Req0Wr(r0_wr), .Req0Length(r0_len),
    .Req0Addr(r0_addr), .Req0WrData(r0_wd), .Req0RdData(rr_rdata0), .Req0Rdy(rr_rdy0),
    .Req1Enable(r1_en), .Req1Rd(r1_rd), .Req1Wr(r1_wr), .Req1Length(r1_len),
    .Req1Addr(r1_addr), .Req1WrData(r1_wd), .Req1RdData(rr_rdata1), .Req1Rdy(rr_rdy1),
    .MemAddr(rr_addr), .toMemData(rr_wd), .fromMemData(from_mem), .MemLength(rr_len),
    .MemRd(rr_rd), .MemWr(rr_wr), .MemEnable(rr_en), .MemRdy(mem_rdy),
    .Grant(rr_grant), .MemErr(rr_err)
  );

  mem_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT_CYCLES(8)) u_fp (
    .Clk(Clk), .Reset(Reset),
    .Req0Enable(r0_en), .Req0Rd(r0_rd), .Req0Wr(r0_wr), .Req0Length(r0_len),
    .Req0Addr(r0_addr), .Req0WrData(r0_wd), .Req0RdData(fp_rdata0), .Req0Rdy(fp_rdy0),
    .Req1Enable(r1_en), .Req1Rd(r1_rd), .Req1Wr(r1_wr), .Req1Length(r1_len),
    .Req1Addr(r1_addr), .Req1WrData(r1_wd), .Req1RdData(fp_rdata1), .Req1Rdy(fp_rdy1),
    .MemAddr(fp_addr), .toMemData(fp_wd), .fromMemData(from_mem), .MemLength(fp_len),
    .MemRd(fp_rd), .MemWr(fp_wr), .MemEnable(fp_en), .MemRdy(mem_rdy),
    .Grant(fp_grant), .MemErr(fp_err)
  );

  typedef struct {
    logic [1:0]  g;
    logic [23:0] a;
    logic [31:0] d;
    logic [2:0]  ctl;   // {rd, wr, len}
    logic [31:0] r0;
    logic [31:0] r1;
  } exp_t;

  typedef struct {
    logic [3:0]  c0;    // {en, rd, wr, len}
    logic [23:0] a0;
    logic [31:0] d0;
    logic [3:0]  c1;
    logic [23:0] a1;
    logic [31:0] d1;
    int          wt;
    logic [31:0] md;
    exp_t        e;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] c0, input logic [23:0] a0, input logic [31:0] d0,
                         input logic [3:0] c1, input logic [23:0] a1, input logic [31:0] d1);
    {r0_en, r0_rd, r0_wr, r0_len} = c0;
    r0_addr = a0;
    r0_wd   = d0;
    {r1_en, r1_rd, r1_wr, r1_len} = c1;
    r1_addr = a1;
    r1_wd   = d1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    mem_rdy  = 1'b0;
    from_mem = '0;
    set_req(4'h0, 24'h0, 32'h0, 4'h0, 24'h0, 32'h0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic chk_access(input string tag, input bit fp, input exp_t e);
    chk({tag, ".en"},    32'(fp ? fp_en : rr_en), 32'd1);
    chk({tag, ".grant"}, 32'(fp ? fp_grant : rr_grant), 32'(e.g));
    chk({tag, ".addr"},  32'(fp ? fp_addr : rr_addr), 32'(e.a));
    chk({tag, ".wdata"}, fp ? fp_wd : rr_wd, e.d);
    chk({tag, ".ctl"},   32'(fp ? {fp_rd, fp_wr, fp_len} : {rr_rd, rr_wr, rr_len}), 32'(e.ctl));
  endtask

  task automatic chk_done(input string tag, input bit fp, input exp_t e);
    chk({tag, ".rdy"},     32'(fp ? {fp_rdy1, fp_rdy0} : {rr_rdy1, rr_rdy0}), 32'(e.g));
    chk({tag, ".mem_off"}, 32'(fp ? {fp_en, fp_rd, fp_wr} : {rr_en, rr_rd, rr_wr}), 32'd0);
    chk({tag, ".grant_hold"}, 32'(fp ? fp_grant : rr_grant), 32'(e.g));
    chk({tag, ".rdata0"},  fp ? fp_rdata0 : rr_rdata0, e.r0);
    chk({tag, ".rdata1"},  fp ? fp_rdata1 : rr_rdata1, e.r1);
    chk({tag, ".err"},     32'(fp ? fp_err : rr_err), 32'd0);
  endtask

  // Requests must be applied and the DUTs idle before the call; returns in IDLE.
  task automatic run_txn(input string tag, input int wt, input logic [31:0] md,
                         input exp_t er, input bit use_fp, input exp_t ef);
    @(posedge Clk); #1;
    chk_access({tag, "/rr"}, 1'b0, er);
    if (use_fp) chk_access({tag, "/fp"}, 1'b1, ef);
    set_req(4'($urandom), 24'($urandom), $urandom, 4'($urandom), 24'($urandom), $urandom);
    for (int k = 0; k < wt; k++) begin
      @(posedge Clk); #1;
      chk({tag, ".wait_en"},   32'(rr_en), 32'd1);
      chk({tag, ".wait_addr"}, 32'(rr_addr), 32'(er.a));
      chk({tag, ".wait_rdy"},  32'({rr_rdy1, rr_rdy0}), 32'd0);
    end
    mem_rdy  = 1'b1;
    from_mem = md;
    @(posedge Clk); #1;
    mem_rdy  = 1'b0;
    from_mem = $urandom;
    chk_done({tag, "/rr"}, 1'b0, er);
    if (use_fp) chk_done({tag, "/fp"}, 1'b1, ef);
    @(posedge Clk); #1;
    chk({tag, ".idle_rr"}, 32'({rr_grant, rr_rdy1, rr_rdy0}), 32'd0);
    if (use_fp) chk({tag, ".idle_fp"}, 32'({fp_grant, fp_rdy1, fp_rdy0}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[6];
    logic [1:0]  rr_q[$];
    logic [1:0]  fp_q[$];
    logic [1:0]  prev_rr, prev_fp;
    int          cnt_rr0, cnt_rr1, cnt_fp0, cnt_fp1, seen;
    logic [31:0] m_rr[2];
    logic [31:0] m_fp[2];
    bit          last_rr;
    logic [3:0]  c[2];
    logic [23:0] a[2];
    logic [31:0] d[2];
    bit          v[2];
    int          wrr, wfp, wt, r;
    logic [31:0] md;
    exp_t        er, ef;

    //            c0       a0           d0            c1       a1           d1            wt  md
    tbl[0] = '{4'b1100, 24'h000010, 32'h00000000, 4'b0000, 24'h000000, 32'h00000000, 2, 32'hCAFE0001,
               '{2'b01, 24'h000010, 32'h00000000, 3'b100, 32'hCAFE0001, 32'h00000000}};
    tbl[1] = '{4'b0000, 24'h000000, 32'h00000000, 4'b1011, 24'hABCDEF, 32'h12345678, 1, 32'h55555555,
               '{2'b10, 24'hABCDEF, 32'h12345678, 3'b011, 32'hCAFE0001, 32'h00000000}};
    tbl[2] = '{4'b1100, 24'h000100, 32'h0000AAAA, 4'b1100, 24'h000200, 32'h0000BBBB, 0, 32'h11112222,
               '{2'b01, 24'h000100, 32'h0000AAAA, 3'b100, 32'h11112222, 32'h00000000}};
    tbl[3] = '{4'b1100, 24'h000100, 32'h0000AAAA, 4'b1101, 24'h000300, 32'h0000CCCC, 3, 32'h33334444,
               '{2'b10, 24'h000300, 32'h0000CCCC, 3'b101, 32'h11112222, 32'h33334444}};
    tbl[4] = '{4'b1110, 24'h000111, 32'h00000000, 4'b1100, 24'h000400, 32'h00000000, 0, 32'h5555AAAA,
               '{2'b10, 24'h000400, 32'h00000000, 3'b100, 32'h11112222, 32'h5555AAAA}};
    tbl[5] = '{4'b1011, 24'h000500, 32'hA5A5A5A5, 4'b1000, 24'h000600, 32'h00000000, 1, 32'h77777777,
               '{2'b01, 24'h000500, 32'hA5A5A5A5, 3'b011, 32'h11112222, 32'h5555AAAA}};

    // Reset values
    Reset    = 1'b1;
    mem_rdy  = 1'b0;
    from_mem = '0;
    set_req(4'h0, 24'h0, 32'h0, 4'h0, 24'h0, 32'h0);
    @(posedge Clk); #1;
    chk("reset.ctl_rr", 32'({rr_en, rr_rd, rr_wr, rr_len, rr_grant, rr_rdy0, rr_rdy1, rr_err}), 32'd0);
    chk("reset.ctl_fp", 32'({fp_en, fp_rd, fp_wr, fp_len, fp_grant, fp_rdy0, fp_rdy1, fp_err}), 32'd0);
    chk("reset.rdata0", rr_rdata0, 32'd0);
    chk("reset.rdata1", rr_rdata1, 32'd0);
    chk("reset.addr", 32'(rr_addr), 32'd0);
    chk("reset.wdata", rr_wd, 32'd0);
    Reset = 1'b0;

    // Directed table on the round-robin copy
    for (int i = 0; i < 6; i++) begin
      set_req(tbl[i].c0, tbl[i].a0, tbl[i].d0, tbl[i].c1, tbl[i].a1, tbl[i].d1);
      run_txn($sformatf("tbl%0d", i), tbl[i].wt, tbl[i].md, tbl[i].e, 1'b0, tbl[i].e);
    end

    // Continuous contention with memory always ready
    do_reset();
    set_req(4'b1100, 24'h000010, 32'h0, 4'b1100, 24'h000020, 32'h0);
    mem_rdy = 1'b1;
    prev_rr = 2'b00; prev_fp = 2'b00;
    cnt_rr0 = 0; cnt_rr1 = 0; cnt_fp0 = 0; cnt_fp1 = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge Clk); #1;
      if (rr_grant != 2'b00 && prev_rr == 2'b00) rr_q.push_back(rr_grant);
      if (fp_grant != 2'b00 && prev_fp == 2'b00) fp_q.push_back(fp_grant);
      prev_rr = rr_grant;
      prev_fp = fp_grant;
      cnt_rr0 += int'(rr_rdy0);
      cnt_rr1 += int'(rr_rdy1);
      cnt_fp0 += int'(fp_rdy0);
      cnt_fp1 += int'(fp_rdy1);
    end
    chk("rr.n_grants", 32'(rr_q.size()), 32'd4);
    for (int k = 0; k < rr_q.size(); k++)
      chk($sformatf("rr.grant%0d", k), 32'(rr_q[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    chk("rr.rdy0_pulses", 32'(cnt_rr0), 32'd2);
    chk("rr.rdy1_pulses", 32'(cnt_rr1), 32'd2);
    chk("fp.n_grants", 32'(fp_q.size()), 32'd4);
    for (int k = 0; k < fp_q.size(); k++)
      chk($sformatf("fp.grant%0d", k), 32'(fp_q[k]), 32'd1);
    chk("fp.rdy0_pulses", 32'(cnt_fp0), 32'd4);
    chk("fp.rdy1_pulses", 32'(cnt_fp1), 32'd0);
    r0_en = 1'b0;
    @(posedge Clk); #1;
    chk("fp.req1_after_drop", 32'(fp_grant), 32'd2);
    mem_rdy = 1'b0;

    // Illegal request, then reset in the middle of an access
    do_reset();
    set_req(4'b1110, 24'h000077, 32'h0, 4'b0000, 24'h0, 32'h0);
    seen = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge Clk); #1;
      seen += int'(rr_en) + int'(fp_en) + int'(rr_grant != 2'b00);
    end
    chk("illegal.no_enable", 32'(seen), 32'd0);
    set_req(4'b1100, 24'h000088, 32'h0, 4'b0000, 24'h0, 32'h0);
    @(posedge Clk); #1;
    chk("rst.pre_en", 32'(rr_en), 32'd1);
    @(posedge Clk); #3;
    Reset = 1'b1;
    #1;
    chk("rst.async_clear", 32'({rr_en, rr_rd, rr_grant, rr_rdy0, rr_rdy1}), 32'd0);
    set_req(4'h0, 24'h0, 32'h0, 4'h0, 24'h0, 32'h0);
    mem_rdy = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge Clk); #1;
      seen += int'(rr_rdy0) + int'(rr_rdy1) + int'(rr_en);
    end
    chk("rst.no_rdy_after", 32'(seen), 32'd0);
    mem_rdy = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: abort after 8 ACCESS cycles
    do_reset();
    set_req(4'b1100, 24'h000099, 32'h0, 4'b0000, 24'h0, 32'h0);
    @(posedge Clk); #1;
    chk("to.en_start", 32'(rr_en), 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(posedge Clk); #1;
      chk($sformatf("to.hold%0d", k), 32'({rr_en, rr_rdy0, rr_err}), 32'b100);
    end
    @(posedge Clk); #1;
    chk("to.abort_ctl", 32'({rr_en, rr_rdy0, rr_err}), 32'b011);
    chk("to.abort_data", rr_rdata0, 32'hDEADBEEF);
    set_req(4'h0, 24'h0, 32'h0, 4'h0, 24'h0, 32'h0);
    @(posedge Clk); #1;
    chk("to.after", 32'({rr_grant, rr_rdy0, rr_err}), 32'd0);
`endif

    // Randomized traffic against a transaction-level model
    do_reset();
    m_rr[0] = '0; m_rr[1] = '0; m_fp[0] = '0; m_fp[1] = '0;
    last_rr = 1'b1;
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 2; j++) begin
        r = int'($urandom_range(0, 5));
        c[j][3] = ($urandom_range(0, 3) != 0);
        case (r)
          0:       c[j][2:1] = 2'b00;
          1:       c[j][2:1] = 2'b11;
          2, 3:    c[j][2:1] = 2'b10;
          default: c[j][2:1] = 2'b01;
        endcase
        c[j][0] = 1'($urandom);
        a[j] = 24'($urandom);
        d[j] = $urandom;
        v[j] = c[j][3] && (c[j][2] != c[j][1]);
      end
      set_req(c[0], a[0], d[0], c[1], a[1], d[1]);
      if (!v[0] && !v[1]) begin
        mem_rdy = 1'b1;
        @(posedge Clk); #1;
        mem_rdy = 1'b0;
        chk($sformatf("rnd%0d.no_grant", i), 32'({rr_en, fp_en, rr_rdy0, rr_rdy1, fp_rdy0, fp_rdy1}), 32'd0);
      end else begin
        wrr = (v[0] && v[1]) ? (last_rr ? 0 : 1) : (v[1] ? 1 : 0);
        wfp = v[0] ? 0 : 1;
        md  = $urandom;
        wt  = int'($urandom_range(0, 3));
        if (c[wrr][2]) m_rr[wrr] = md;
        if (c[wfp][2]) m_fp[wfp] = md;
        er = '{(wrr == 1) ? 2'b10 : 2'b01, a[wrr], d[wrr], c[wrr][2:0], m_rr[0], m_rr[1]};
        ef = '{(wfp == 1) ? 2'b10 : 2'b01, a[wfp], d[wfp], c[wfp][2:0], m_fp[0], m_fp[1]};
        run_txn($sformatf("rnd%0d", i), wt, md, er, 1'b1, ef);
        last_rr = (wrr == 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
